// File: rtl/ste_audio_pkg.sv
// Shared definitions for the STE LMC1992 emulation: command/mixer codes,
// register reset defaults and volume limits.
package ste_audio_pkg;

    typedef enum logic [2:0] {
        LMC_CMD_MIX    = 3'b000,
        LMC_CMD_BASS   = 3'b001,
        LMC_CMD_TREBLE = 3'b010,
        LMC_CMD_MASTER = 3'b011,
        LMC_CMD_RIGHT  = 3'b100,
        LMC_CMD_LEFT   = 3'b101
    } lmc_cmd_e;

    typedef enum logic [1:0] {
        MIX_PSG_M12 = 2'b00,
        MIX_PSG     = 2'b01,
        MIX_DMA     = 2'b10,
        MIX_RSVD    = 2'b11
    } mix_e;

    localparam logic [5:0] BASS_RST     = 6'd6;
    localparam logic [5:0] TREBLE_RST   = 6'd6;
    localparam logic [5:0] MASTER_RST   = 6'd40;
    localparam logic [5:0] VOL_LR_RST   = 6'd20;
    localparam logic [5:0] MASTER_MAX   = 6'd40;
    localparam logic [5:0] VOL_LR_MAX   = 6'd20;
    localparam logic [5:0] TONE_MAX     = 6'd12;
    localparam logic [5:0] LMC_MUTE_ATT = 6'd48;

    function automatic logic [5:0] clamp_val(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/lmc_gain_rom.sv
// Attenuation index (2 dB steps) to Q1.15 gain, round(32767 * 10^(-att/10)).
// Indices at or above LMC_MUTE_ATT are a hard mute.
module lmc_gain_rom
    import ste_audio_pkg::*;
(
    input  logic [5:0]  att_i,
    output logic [15:0] gain_o
);

    always_comb begin
        gain_o = 16'd0;
        if (att_i < LMC_MUTE_ATT) begin
            case (att_i)
                6'd0:  gain_o = 16'd32767;  6'd1:  gain_o = 16'd26028;
                6'd2:  gain_o = 16'd20675;  6'd3:  gain_o = 16'd16422;
                6'd4:  gain_o = 16'd13045;  6'd5:  gain_o = 16'd10362;
                6'd6:  gain_o = 16'd8231;   6'd7:  gain_o = 16'd6538;
                6'd8:  gain_o = 16'd5193;   6'd9:  gain_o = 16'd4125;
                6'd10: gain_o = 16'd3277;   6'd11: gain_o = 16'd2603;
                6'd12: gain_o = 16'd2067;   6'd13: gain_o = 16'd1642;
                6'd14: gain_o = 16'd1304;   6'd15: gain_o = 16'd1036;
                6'd16: gain_o = 16'd823;    6'd17: gain_o = 16'd654;
                6'd18: gain_o = 16'd519;    6'd19: gain_o = 16'd413;
                6'd20: gain_o = 16'd328;    6'd21: gain_o = 16'd260;
                6'd22: gain_o = 16'd207;    6'd23: gain_o = 16'd164;
                6'd24: gain_o = 16'd130;    6'd25: gain_o = 16'd104;
                6'd26: gain_o = 16'd82;     6'd27: gain_o = 16'd65;
                6'd28: gain_o = 16'd52;     6'd29: gain_o = 16'd41;
                6'd30: gain_o = 16'd33;     6'd31: gain_o = 16'd26;
                6'd32: gain_o = 16'd21;     6'd33: gain_o = 16'd16;
                6'd34: gain_o = 16'd13;     6'd35: gain_o = 16'd10;
                6'd36: gain_o = 16'd8;      6'd37: gain_o = 16'd7;
                6'd38: gain_o = 16'd5;      6'd39: gain_o = 16'd4;
                6'd40: gain_o = 16'd3;      6'd41: gain_o = 16'd3;
                6'd42: gain_o = 16'd2;      6'd43: gain_o = 16'd2;
                6'd44: gain_o = 16'd1;      6'd45: gain_o = 16'd1;
                6'd46: gain_o = 16'd1;      6'd47: gain_o = 16'd1;
                default: gain_o = 16'd0;
            endcase
        end
    end

endmodule

// File: rtl/ste_lmc1992.sv
// LMC1992 emulation: microwire receiver, register file and 3-stage mix/attenuate
// pipeline. Define STE_LMC_RAMP_EN to ramp attenuation one step per sample.
module ste_lmc1992
    import ste_audio_pkg::*;
#(
    parameter int         MW_BITS = 11,
    parameter logic [1:0] MW_ADDR = 2'b10,
    parameter int         OUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mw_strobe,
    input  logic                    mw_valid,
    input  logic                    mw_data,
    input  logic                    mw_done,
    input  logic                    sample_en,
    input  logic [7:0]              dma_l,
    input  logic [7:0]              dma_r,
    input  logic signed [15:0]      psg,
    output logic signed [OUT_W-1:0] audio_l,
    output logic signed [OUT_W-1:0] audio_r,
    output logic                    out_valid
);

    localparam logic signed [16:0] SAT_MAX = 17'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [16:0] SAT_MIN = -SAT_MAX - 17'sd1;

    function automatic logic signed [16:0] mix_sum(input logic signed [15:0] d,
                                                   input logic signed [15:0] ps,
                                                   input mix_e m);
        logic signed [16:0] de;
        logic signed [16:0] pe;
        logic signed [16:0] s;
        de = 17'(d);
        pe = 17'(ps);
        case (m)
            MIX_PSG_M12: s = de + (pe >>> 2);
            MIX_PSG:     s = de + pe;
            default:     s = de;
        endcase
        return s;
    endfunction

    function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [16:0] s,
                                                          input logic [15:0] g);
        logic signed [33:0] p;
        logic signed [16:0] q;
        logic signed [OUT_W-1:0] r;
        p = 34'(s) * $signed({18'd0, g});
        q = 17'(p >>> 15);
        if (q > SAT_MAX)      r = OUT_W'(SAT_MAX);
        else if (q < SAT_MIN) r = OUT_W'(SAT_MIN);
        else                  r = OUT_W'(q);
        return r;
    endfunction

    logic [10:0] sr_q, sr_d, frame;
    logic [3:0]  cnt_q, cnt_d;
    logic        frame_ok;
    mix_e        mix_q, mix_d;
    logic [5:0]  bass_q, bass_d, treble_q, treble_d;
    logic [5:0]  master_q, master_d, left_q, left_d, right_q, right_d;
    logic        unused_tone;

    // A shift coinciding with mw_done is folded in before the frame is judged.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        mix_d    = mix_q;
        bass_d   = bass_q;
        treble_d = treble_q;
        master_d = master_q;
        left_d   = left_q;
        right_d  = right_q;
        frame_ok = 1'b0;
        if (mw_strobe && mw_valid) begin
            sr_d  = {sr_q[9:0], mw_data};
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
        frame = sr_d;
        if (mw_done) begin
            frame_ok = (cnt_d == 4'(MW_BITS)) && (sr_d[10:9] == MW_ADDR);
            sr_d     = '0;
            cnt_d    = '0;
        end
        if (frame_ok) begin
            case (frame[8:6])
                LMC_CMD_MIX:    if (frame[1:0] != MIX_RSVD) mix_d = mix_e'(frame[1:0]);
                LMC_CMD_BASS:   bass_d   = clamp_val(frame[5:0], TONE_MAX);
                LMC_CMD_TREBLE: treble_d = clamp_val(frame[5:0], TONE_MAX);
                LMC_CMD_MASTER: master_d = clamp_val(frame[5:0], MASTER_MAX);
                LMC_CMD_RIGHT:  right_d  = clamp_val(frame[5:0], VOL_LR_MAX);
                LMC_CMD_LEFT:   left_d   = clamp_val(frame[5:0], VOL_LR_MAX);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            mix_q    <= MIX_PSG;
            bass_q   <= BASS_RST;
            treble_q <= TREBLE_RST;
            master_q <= MASTER_RST;
            left_q   <= VOL_LR_RST;
            right_q  <= VOL_LR_RST;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            mix_q    <= mix_d;
            bass_q   <= bass_d;
            treble_q <= treble_d;
            master_q <= master_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    // Tone registers are held for read-back fidelity only; no filter uses them.
    assign unused_tone = ^{bass_q, treble_q};

    logic [5:0] att_tgt_l, att_tgt_r, att_s1_l, att_s1_r;

    assign att_tgt_l = (MASTER_MAX - master_q) + (VOL_LR_MAX - left_q);
    assign att_tgt_r = (MASTER_MAX - master_q) + (VOL_LR_MAX - right_q);

`ifdef STE_LMC_RAMP_EN
    logic [5:0] att_cur_l_q, att_cur_l_d, att_cur_r_q, att_cur_r_d;

    function automatic logic [5:0] ramp_step(input logic [5:0] cur, input logic [5:0] tgt);
        if (cur < tgt) return cur + 6'd1;
        if (cur > tgt) return cur - 6'd1;
        return cur;
    endfunction

    always_comb begin
        att_cur_l_d = att_cur_l_q;
        att_cur_r_d = att_cur_r_q;
        if (sample_en) begin
            att_cur_l_d = ramp_step(att_cur_l_q, att_tgt_l);
            att_cur_r_d = ramp_step(att_cur_r_q, att_tgt_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            att_cur_l_q <= '0;
            att_cur_r_q <= '0;
        end else begin
            att_cur_l_q <= att_cur_l_d;
            att_cur_r_q <= att_cur_r_d;
        end
    end

    assign att_s1_l = att_cur_l_d;
    assign att_s1_r = att_cur_r_d;
`else
    assign att_s1_l = att_tgt_l;
    assign att_s1_r = att_tgt_r;
`endif

    logic signed [15:0] d_l_p1_q, d_r_p1_q, psg_p1_q;
    mix_e               mix_p1_q;
    logic [5:0]         att_l_p1_q, att_r_p1_q;
    logic               vld_p1_q, vld_p2_q;
    logic [15:0]        gain_l, gain_r, gain_l_p2_q, gain_r_p2_q;
    logic signed [16:0] sum_l_p2_q, sum_r_p2_q;
    logic signed [OUT_W-1:0] audio_l_q, audio_r_q;
    logic               out_valid_q;

    // S1: capture inputs and the attenuation in force for this sample
    always_ff @(posedge clk) begin
        if (sample_en) begin
            d_l_p1_q   <= $signed({dma_l ^ 8'h80, 8'h00});
            d_r_p1_q   <= $signed({dma_r ^ 8'h80, 8'h00});
            psg_p1_q   <= psg;
            mix_p1_q   <= mix_q;
            att_l_p1_q <= att_s1_l;
            att_r_p1_q <= att_s1_r;
        end
    end

    lmc_gain_rom u_gain_l (.att_i(att_l_p1_q), .gain_o(gain_l));
    lmc_gain_rom u_gain_r (.att_i(att_r_p1_q), .gain_o(gain_r));

    // S2: mix and gain lookup
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            sum_l_p2_q  <= mix_sum(d_l_p1_q, psg_p1_q, mix_p1_q);
            sum_r_p2_q  <= mix_sum(d_r_p1_q, psg_p1_q, mix_p1_q);
            gain_l_p2_q <= gain_l;
            gain_r_p2_q <= gain_r;
        end
    end

    // S3: scale and saturate into the output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
        end else begin
            vld_p1_q    <= sample_en;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
            if (vld_p2_q) begin
                audio_l_q <= scale_sat(sum_l_p2_q, gain_l_p2_q);
                audio_r_q <= scale_sat(sum_r_p2_q, gain_r_p2_q);
            end
        end
    end

    assign audio_l   = audio_l_q;
    assign audio_r   = audio_r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ste_lmc1992.sv
// Directed + randomized bench for ste_lmc1992 against an arithmetic reference
// model of the register rules, dB gain law and 3-cycle output latency.
module tb_ste_lmc1992;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mw_strobe = 1'b0, mw_valid = 1'b0, mw_data = 1'b0, mw_done = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  dma_l = 8'h80, dma_r = 8'h80;
    logic [15:0] psg = 16'h0000;
    logic [15:0] audio_l, audio_r;
    logic        out_valid;

    int n_vec = 0;
    int n_err = 0;

    int m_mix, m_master, m_left, m_right, cur_l, cur_r;

    ste_lmc1992 dut (
        .clk(clk), .reset_n(reset_n),
        .mw_strobe(mw_strobe), .mw_valid(mw_valid), .mw_data(mw_data), .mw_done(mw_done),
        .sample_en(sample_en), .dma_l(dma_l), .dma_r(dma_r), .psg(psg),
        .audio_l(audio_l), .audio_r(audio_r), .out_valid(out_valid)
    );

    always #16 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gain(input int att);
        if (att >= 48) return 0;
        return int'($floor(32767.0 * $pow(10.0, -real'(att) / 10.0) + 0.5));
    endfunction

    function automatic logic [15:0] model_out(input int dma, input int ps, input int mix, input int att);
        longint s, p, q;
        s = longint'(dma - 128) * 256;
        if (mix == 0)      s += longint'($floor(real'(ps) / 4.0));
        else if (mix == 1) s += longint'(ps);
        p = s * longint'(gain(att));
        q = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mix = 1; m_master = 40; m_left = 20; m_right = 20;
        cur_l = 0; cur_r = 0;
    endtask

    task automatic model_att(output int al, output int ar);
        int tl, tr;
        tl = (40 - m_master) + (20 - m_left);
        tr = (40 - m_master) + (20 - m_right);
`ifdef STE_LMC_RAMP_EN
        if (cur_l < tl) cur_l++; else if (cur_l > tl) cur_l--;
        if (cur_r < tr) cur_r++; else if (cur_r > tr) cur_r--;
        al = cur_l; ar = cur_r;
`else
        al = tl; ar = tr;
`endif
    endtask

    task automatic do_reset();
        sample_en = 1'b0; mw_strobe = 1'b0; mw_valid = 1'b0; mw_done = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic send_frame(input int addr, input int cmd, input int val,
                              input int nbits, input bit merge_done);
        logic [11:0] w;
        w = 12'((addr << 9) | (cmd << 6) | val);
        for (int i = nbits - 1; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) begin
                mw_strobe = 1'b1; mw_valid = 1'b0; mw_data = 1'($urandom);
                tick();
            end
            mw_strobe = 1'b1; mw_valid = 1'b1; mw_data = w[i];
            mw_done = (i == 0) && merge_done;
            tick();
            mw_strobe = 1'b0; mw_valid = 1'b0; mw_done = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        if (!merge_done) begin
            mw_done = 1'b1;
            tick();
            mw_done = 1'b0;
        end
        tick();
        if (nbits == 11 && addr == 2) begin
            case (cmd)
                0: if (val % 4 != 3) m_mix = val % 4;
                3: m_master = imin(val, 40);
                4: m_right  = imin(val, 20);
                5: m_left   = imin(val, 20);
                default: ;
            endcase
        end
    endtask

    task automatic do_sample(input logic [7:0] dl, input logic [7:0] dr, input logic [15:0] ps);
        int al, ar;
        logic [15:0] el, er;
        model_att(al, ar);
        el = model_out(int'(dl), int'($signed(ps)), m_mix, al);
        er = model_out(int'(dr), int'($signed(ps)), m_mix, ar);
        dma_l = dl; dma_r = dr; psg = ps; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        dma_l = 8'($urandom); dma_r = 8'($urandom); psg = 16'($urandom);
        tick();
        chk("valid_early", 16'(out_valid), 16'd0);
        tick();
        chk("valid", 16'(out_valid), 16'd1);
        chk("audio_l", audio_l, el);
        chk("audio_r", audio_r, er);
        tick();
        chk("valid_pulse", 16'(out_valid), 16'd0);
    endtask

    task automatic warm(input int n);
        for (int i = 0; i < n; i++)
            do_sample(8'($urandom), 8'($urandom), 16'($urandom));
    endtask

    initial begin
        logic [15:0] el_q [5];
        logic [15:0] er_q [5];
        logic [7:0]  bl, br;
        logic [15:0] bp;
        int al, ar;

        model_reset();
        tick();
        // Reset state
        do_reset();
        chk("rst_audio_l", audio_l, 16'h0000);
        chk("rst_audio_r", audio_r, 16'h0000);
        chk("rst_valid", 16'(out_valid), 16'd0);
        do_sample(8'hC0, 8'h40, 16'h1234);
        do_sample(8'h80, 8'h80, 16'h2000);

        // Master and left writes, DMA-only mix
        send_frame(2, 3, 40, 11, 1'b0);
        send_frame(2, 5, 10, 11, 1'b1);
        send_frame(2, 0, 2, 11, 1'b0);
        warm(12);
        do_sample(8'hC0, 8'hC0, 16'h0000);
        chk("t2_left_0666", audio_l, 16'h0666);
        chk("t2_right_3fff", audio_r, 16'h3FFF);

        // Short, long and wrong-address frames are discarded
        send_frame(2, 5, 3, 10, 1'b0);
        send_frame(1, 5, 3, 11, 1'b1);
        send_frame(2, 5, 3, 12, 1'b1);
        do_sample(8'hC0, 8'hC0, 16'h0000);
        chk("t3_left_kept", audio_l, 16'h0666);
        send_frame(2, 5, 15, 11, 1'b0);
        warm(6);

        // Reset in the middle of a transfer drops the partial frame
        for (int i = 0; i < 5; i++) begin
            mw_strobe = 1'b1; mw_valid = 1'b1; mw_data = 1'($urandom);
            tick();
        end
        mw_strobe = 1'b0; mw_valid = 1'b0;
        do_reset();
        send_frame(2, 3, 35, 11, 1'b1);
        warm(6);

        // Saturation at both extremes
        send_frame(2, 0, 1, 11, 1'b0);
        send_frame(2, 3, 40, 11, 1'b0);
        send_frame(2, 5, 20, 11, 1'b0);
        send_frame(2, 4, 20, 11, 1'b0);
        warm(12);
        do_sample(8'hFF, 8'h80, 16'h7FFF);
        chk("sat_pos", audio_l, 16'h7FFF);
        do_sample(8'h00, 8'h80, 16'h8000);
        chk("sat_neg", audio_l, 16'h8000);

        // Clamping and reserved mix code
        send_frame(2, 3, 20, 11, 1'b0);
        send_frame(2, 3, 63, 11, 1'b1);
        send_frame(2, 5, 5, 11, 1'b0);
        send_frame(2, 5, 50, 11, 1'b0);
        send_frame(2, 0, 3, 11, 1'b0);
        send_frame(2, 0, 0, 11, 1'b0);
        warm(6);
        send_frame(2, 4, 63, 11, 1'b0);
        send_frame(2, 3, 0, 11, 1'b0);
        warm(4);

        // Back-to-back samples
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                bl = 8'($urandom); br = 8'($urandom); bp = 16'($urandom);
                model_att(al, ar);
                el_q[k] = model_out(int'(bl), int'($signed(bp)), m_mix, al);
                er_q[k] = model_out(int'(br), int'($signed(bp)), m_mix, ar);
                dma_l = bl; dma_r = br; psg = bp; sample_en = 1'b1;
            end else begin
                sample_en = 1'b0;
                dma_l = 8'($urandom); dma_r = 8'($urandom); psg = 16'($urandom);
            end
            tick();
            if (k >= 2 && k < 7) begin
                chk("b2b_valid", 16'(out_valid), 16'd1);
                chk("b2b_l", audio_l, el_q[k-2]);
                chk("b2b_r", audio_r, er_q[k-2]);
            end else begin
                chk("b2b_idle", 16'(out_valid), 16'd0);
            end
        end

        // Master 40 -> 30 with and without the attenuation ramp
        send_frame(2, 0, 2, 11, 1'b0);
        send_frame(2, 3, 40, 11, 1'b0);
        send_frame(2, 5, 20, 11, 1'b0);
        send_frame(2, 4, 20, 11, 1'b0);
        warm(30);
        send_frame(2, 3, 30, 11, 1'b1);
        do_sample(8'hC0, 8'hC0, 16'h0000);
`ifdef STE_LMC_RAMP_EN
        chk("ramp_first", audio_l, 16'h32D6);
`else
        chk("ramp_first", audio_l, 16'h0666);
`endif
        warm(8);
        do_sample(8'hC0, 8'hC0, 16'h0000);
        chk("ramp_tenth", audio_l, 16'h0666);

        // Reset while a sample is in flight
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("inflight_v0", 16'(out_valid), 16'd0);
        tick();
        reset_n = 1'b1;
        model_reset();
        chk("inflight_v1", 16'(out_valid), 16'd0);
        chk("inflight_al", audio_l, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inflight_idle", 16'(out_valid), 16'd0);
        end

        // Randomized frames and samples
        for (int it = 0; it < 40; it++) begin
            int nb, ad, sel;
            sel = int'($urandom_range(0, 5));
            nb = (sel == 0) ? 10 : (sel == 1) ? 12 : 11;
            ad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 2;
            send_frame(ad, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), nb,
                       1'($urandom));
            for (int j = 0; j < int'($urandom_range(1, 2)); j++)
                do_sample(8'($urandom), 8'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
